// File: rtl/decode_issue_buffer.sv
// Decode issue buffer: holds one fetch group of up to LANES instructions and presents pre-decoded
// register fields. Unissued lanes compact to lane 0. Optional macro DECODE_PERF_CNT_EN adds perf counters.
module decode_issue_buffer #(
  parameter int LANES  = 2,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        in_valid_i,
  input  logic [LANES*PC_W-1:0]   in_pc_i,
  input  logic [LANES*INST_W-1:0] in_inst_i,
  output logic                    in_ready_o,
  input  logic [CNT_W-1:0]        issue_cnt_i,
  output logic [LANES-1:0]        dec_valid_o,
  output logic [LANES*PC_W-1:0]   dec_pc_o,
  output logic [LANES*INST_W-1:0] dec_inst_o,
  output logic [LANES*5-1:0]      dec_rs1_o,
  output logic [LANES*5-1:0]      dec_rs2_o,
  output logic [LANES*5-1:0]      dec_rs3_o,
  output logic [LANES*5-1:0]      dec_rd_o,
  output logic [LANES-1:0]        dec_endsim_o,
  output logic [CNT_W-1:0]        occ_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cyc_o,
  output logic [31:0]             perf_issued_o
`endif
);

  localparam logic [INST_W-1:0] ENDSIM_INST = INST_W'(32'h0000_006B);

  logic [PC_W-1:0]   pc_q   [LANES];
  logic [INST_W-1:0] inst_q [LANES];
  logic [PC_W-1:0]   pc_d   [LANES];
  logic [INST_W-1:0] inst_d [LANES];
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_d;
  logic [CNT_W-1:0]  eff;
  logic [CNT_W-1:0]  in_cnt;

  // Downstream may offer more slots than we hold; the excess is simply unused.
  assign eff        = (issue_cnt_i > occ_q) ? occ_q : issue_cnt_i;
  assign in_ready_o = (occ_q == '0) || (eff == occ_q);
  assign occ_o      = occ_q;

  always_comb begin
    in_cnt = '0;
    for (int k = 0; k < LANES; k++) in_cnt = in_cnt + CNT_W'(in_valid_i[k]);
  end

  // NOTE: every variable is given a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    occ_d = occ_q;
    for (int k = 0; k < LANES; k++) begin
      pc_d[k]   = pc_q[k];
      inst_d[k] = inst_q[k];
    end
    if (flush_i) begin
      occ_d = '0;
      for (int k = 0; k < LANES; k++) begin
        pc_d[k]   = '0;
        inst_d[k] = '0;
      end
    end else if (in_ready_o) begin
      // Held group fully drains this cycle; an empty input leaves the buffer empty.
      occ_d = in_cnt;
      if (|in_valid_i) begin
        for (int k = 0; k < LANES; k++) begin
          pc_d[k]   = in_pc_i[k*PC_W +: PC_W];
          inst_d[k] = in_inst_i[k*INST_W +: INST_W];
        end
      end
    end else begin
      occ_d = occ_q - eff;
      // Compact survivors towards lane 0; lanes with no source are zero-filled.
      for (int k = 0; k < LANES; k++) begin
        pc_d[k]   = '0;
        inst_d[k] = '0;
        for (int s = k; s < LANES; s++) begin
          if (s == k + int'(eff)) begin
            pc_d[k]   = pc_q[s];
            inst_d[k] = inst_q[s];
          end
        end
      end
    end
  end

  // NOTE: the lane array is reset together with occ so the field outputs read 0, not X, out of reset.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        pc_q[k]   <= '0;
        inst_q[k] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int k = 0; k < LANES; k++) begin
        pc_q[k]   <= pc_d[k];
        inst_q[k] <= inst_d[k];
      end
    end
  end

  always_comb begin
    dec_valid_o  = '0;
    dec_pc_o     = '0;
    dec_inst_o   = '0;
    dec_rs1_o    = '0;
    dec_rs2_o    = '0;
    dec_rs3_o    = '0;
    dec_rd_o     = '0;
    dec_endsim_o = '0;
    for (int k = 0; k < LANES; k++) begin
      dec_valid_o[k]               = (k < int'(occ_q)) && !flush_i;
      dec_pc_o[k*PC_W +: PC_W]     = pc_q[k];
      dec_inst_o[k*INST_W +: INST_W] = inst_q[k];
      dec_rs1_o[k*5 +: 5]          = inst_q[k][19:15];
      dec_rs2_o[k*5 +: 5]          = inst_q[k][24:20];
      dec_rs3_o[k*5 +: 5]          = inst_q[k][31:27];
      dec_rd_o[k*5 +: 5]           = inst_q[k][11:7];
      dec_endsim_o[k]              = (inst_q[k] == ENDSIM_INST);
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] issued_q;

  // Counters are statistics only: flush suppresses counting but never clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else if (!flush_i) begin
      if ((occ_q != '0) && (eff == '0)) stall_q <= stall_q + 32'd1;
      issued_q <= issued_q + 32'(eff);
    end
  end

  assign perf_stall_cyc_o = stall_q;
  assign perf_issued_o    = issued_q;
`endif

  valid_prefix_a: assert property (@(posedge clk) disable iff (rst)
    ((in_valid_i & (in_valid_i + LANES'(1))) == '0));

endmodule

// File: doc/decode_issue_buffer.md
Name: decode_issue_buffer

Overview:
- Parametrised successor to the fixed two-lane decode stage register.
- Holds one fetch group of up to LANES instructions and presents pre-decoded register fields to the operand/scoreboard stage.
- Supports in-order partial issue: unissued lanes compact to lane 0 and are re-presented; a new group is accepted only once the held group drains.
- Sits between the instruction queue (fetch F1) and the operand-read stage.

Parameters:
LANES, 2, number of decode lanes (1..8)
PC_W, 64, program counter width
INST_W, 32, instruction width (fixed 32 for RV encodings)
CNT_W, $clog2(LANES+1), width of lane-count fields (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_i  in  1  flush from writeback; discards held and incoming group
in_valid_i  in  LANES  per-lane valid from instruction queue; must be a contiguous prefix from bit 0
in_pc_i  in  LANES*PC_W  per-lane PC, lane k at [k*PC_W +: PC_W]
in_inst_i  in  LANES*32  per-lane instruction word
in_ready_o  out  1  buffer will capture the incoming group at this clock edge
issue_cnt_i  in  CNT_W  lanes accepted downstream this cycle, in order from lane 0
dec_valid_o  out  LANES  per-lane valid; always a contiguous prefix
dec_pc_o  out  LANES*PC_W  held PC per lane
dec_inst_o  out  LANES*32  held instruction per lane
dec_rs1_o / dec_rs2_o / dec_rs3_o  out  LANES*5  inst[19:15] / [24:20] / [31:27]
dec_rd_o  out  LANES*5  inst[11:7]
dec_endsim_o  out  LANES  lane instruction == 32'h0000_006B
occ_o  out  CNT_W  number of held valid lanes

Behaviour:
- State: lane array (pc, inst) of LANES entries; occupancy counter occ (0..LANES).
- Reset: occ=0; all pc/inst entries 0. Outputs: dec_valid_o=0, occ_o=0, all field outputs 0, dec_endsim_o=0. in_ready_o=1 once reset is removed.
- Effective issue: eff = min(issue_cnt_i, occ). Values above occ are clamped; this is never an error.
- in_ready_o = (occ==0) | (eff==occ). Combinational from occ and issue_cnt_i.
- dec_valid_o[k] = (k < occ) & !flush_i. Field outputs are combinational decode of the held inst, so output latency is 1 cycle from capture.
- Next state (priority order):
  1. flush_i: occ<=0; entries cleared to 0; the incoming group is dropped.
  2. in_ready_o & |in_valid_i: capture the group into lanes 0..LANES-1; occ <= popcount(in_valid_i). Lanes beyond the valid prefix are written but ignored.
  3. in_ready_o & no input valid: occ <= 0.
  4. Otherwise (partial issue, eff<occ): entry[k] <= entry[k+eff] for k < occ-eff; occ <= occ-eff. eff=0 holds all state.
- Partial issue and capture are never simultaneous; a new group waits until the held group fully issues.
- Non-prefix in_valid_i is illegal: assertion in simulation, no defined behaviour.
- Mid-operation reset clears occ immediately (asynchronous). Outputs go invalid in the same cycle.

Optional Feature:
DECODE_PERF_CNT_EN:
- Defined: adds 32-bit output perf_stall_cyc_o, incremented when occ>0 & eff==0 & !flush_i, and 32-bit output perf_issued_o, incremented by eff each cycle when !flush_i.
- Both counters wrap modulo 2^32, reset to 0 on rst, and are unaffected by flush_i.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset, LANES=2: rst=1 → dec_valid_o=2'b00, occ_o=0. After release, in_ready_o=1.
- Group pc={0x1004,0x1000}, inst lane0=0x00B50533 (add a0,a0,a1), valid=2'b11, issue_cnt=0 → next cycle dec_valid_o=2'b11, lane0 rs1=10, rs2=11, rd=10, in_ready_o=0.
- Held 2 lanes, issue_cnt=1 → next cycle occ=1, lane0 pc=0x1004, dec_valid_o=2'b01. Then issue_cnt=1 with a new group on input → in_ready_o=1 and the new group is captured.
- Held 2 lanes, issue_cnt=3 (CNT_W=2) → clamped to 2, group drains, and a simultaneous input is captured.
- flush_i=1 with occ=2 and input valid=2'b11 → dec_valid_o=0 in the same cycle, occ=0 next cycle, input dropped.
- LANES=4: lane2 inst=0x0000006B captured → dec_endsim_o=4'b0100. issue_cnt=2 → next cycle dec_endsim_o=4'b0001. With DECODE_PERF_CNT_EN, perf_issued_o=2.
